// File: rtl/boot_rom_loader.sv
// Runtime-loadable boot ROM: packs 16-bit download words into a byte RAM,
// serves the CPU's registered boot-ROM read port and holds the FF50 disable latch.
module boot_rom_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  FILL   = 8'hFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [15:0]       dl_addr,
  input  logic [15:0]       dl_data,
  output logic              dl_wait,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  input  logic              ff50_wr,
  input  logic [7:0]        ff50_din,
  output logic              boot_enabled,
  output logic              rom_valid,
  output logic [7:0]        checksum
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    HI,
    READY
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] hi_addr;
  logic [7:0]        hi_byte;
  logic [7:0]        mem [DEPTH];

  logic              word_in_range;
  logic              load_accept;
  logic [ADDR_W-1:0] lo_addr;
  logic [ADDR_W:0]   count_inc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              unused_bits;

  // A word is even-aligned, so A+1 fits exactly when no bit above ADDR_W-1 is set.
  assign word_in_range = (dl_addr[15:ADDR_W] == '0);
  assign lo_addr       = {dl_addr[ADDR_W-1:1], 1'b0};
  assign load_accept   = (state == LOAD) && dl_active && dl_wr && word_in_range;
  assign count_inc     = (count == CNT_FULL) ? count : count + 1'b1;
  assign unused_bits   = ^{dl_addr[0], ff50_din[7:1]};

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = lo_addr;
    mem_wdata = dl_data[7:0];
    if (load_accept) begin
      mem_we = 1'b1;
    end else if (state == HI) begin
      mem_we    = 1'b1;
      mem_waddr = hi_addr;
      mem_wdata = hi_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= EMPTY;
      count        <= '0;
      checksum     <= '0;
      hi_addr      <= '0;
      hi_byte      <= '0;
      dl_wait      <= 1'b0;
      rom_valid    <= 1'b0;
      boot_enabled <= 1'b0;
    end else begin
      case (state)
        EMPTY, READY: begin
          if (dl_active) begin
            state     <= LOAD;
            count     <= '0;
            checksum  <= '0;
            rom_valid <= 1'b0;
          end
        end
        LOAD: begin
          if (!dl_active) begin
            if (count == CNT_FULL) begin
              state        <= READY;
              rom_valid    <= 1'b1;
              boot_enabled <= 1'b1;
            end else begin
              state <= EMPTY;
            end
          end else if (load_accept) begin
            hi_addr  <= {dl_addr[ADDR_W-1:1], 1'b1};
            hi_byte  <= dl_data[15:8];
            count    <= count_inc;
            checksum <= checksum + dl_data[7:0];
            dl_wait  <= 1'b1;
            state    <= HI;
          end
        end
        HI: begin
          count    <= count_inc;
          checksum <= checksum + hi_byte;
          dl_wait  <= 1'b0;
          state    <= LOAD;
        end
        default: state <= EMPTY;
      endcase
      // Placed last so an FF50 clear overrides a same-cycle READY entry.
      if (ff50_wr && ff50_din[0]) begin
        boot_enabled <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_data <= FILL;
    end else begin
      cpu_data <= rom_valid ? mem[cpu_addr] : FILL;
    end
  end

endmodule

// File: tb/tb_boot_rom_loader.sv
// Directed/randomized bench for boot_rom_loader against a transaction-level
// image model (byte array, running sum, byte count).
module tb_boot_rom_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dl_active;
  logic        dl_wr;
  logic [15:0] dl_addr;
  logic [15:0] dl_data;
  logic        dl_wait;
  logic [7:0]  cpu_addr;
  logic [7:0]  cpu_data;
  logic        ff50_wr;
  logic [7:0]  ff50_din;
  logic        boot_enabled;
  logic        rom_valid;
  logic [7:0]  checksum;

  int checks = 0;
  int errors = 0;

  logic [7:0] mmem [256];
  int         model_cnt;
  logic [7:0] model_sum;
  logic       model_valid;
  logic       model_be;
  int         order [128];

  boot_rom_loader #(.ADDR_W(8), .FILL(8'hFF)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .dl_active   (dl_active),
    .dl_wr       (dl_wr),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .dl_wait     (dl_wait),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .ff50_wr     (ff50_wr),
    .ff50_din    (ff50_din),
    .boot_enabled(boot_enabled),
    .rom_valid   (rom_valid),
    .checksum    (checksum)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_cnt   = 0;
    model_sum   = 8'h00;
    model_valid = 1'b0;
    model_be    = 1'b0;
  endtask

  task automatic start_session();
    dl_active = 1'b1;
    tick();
    model_cnt   = 0;
    model_sum   = 8'h00;
    model_valid = 1'b0;
    chk1("rom_valid_in_session", rom_valid, 1'b0);
  endtask

  task automatic send_word(input logic [15:0] addr, input logic [15:0] data);
    int a;
    logic ok;
    a  = int'(addr) & 32'hFFFE;
    ok = (a + 1 < 256);
    dl_addr = addr;
    dl_data = data;
    dl_wr   = 1'b1;
    tick();
    dl_wr = 1'b0;
    chk1("dl_wait_e0", dl_wait, ok);
    tick();
    chk1("dl_wait_e1", dl_wait, 1'b0);
    if (ok) begin
      mmem[a]     = data[7:0];
      mmem[a + 1] = data[15:8];
      model_sum   = model_sum + data[7:0] + data[15:8];
      model_cnt   = (model_cnt + 2 > 256) ? 256 : model_cnt + 2;
    end
  endtask

  task automatic end_session(input logic ff50_same);
    dl_active = 1'b0;
    if (ff50_same) begin
      ff50_wr  = 1'b1;
      ff50_din = 8'h01;
    end
    tick();
    ff50_wr = 1'b0;
    if (model_cnt == 256) begin
      model_valid = 1'b1;
      model_be    = !ff50_same;
      chk1("boot_enabled_end", boot_enabled, model_be);
    end
    chk1("rom_valid_end", rom_valid, model_valid);
    chk8("checksum_end", checksum, model_sum);
  endtask

  task automatic read_chk(input logic [7:0] addr);
    cpu_addr = addr;
    tick();
    chk8("cpu_data", cpu_data, model_valid ? mmem[addr] : 8'hFF);
  endtask

  task automatic random_full_load(input logic ff50_same);
    for (int i = 0; i < 128; i++) order[i] = i;
    for (int i = 127; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    start_session();
    for (int i = 0; i < 128; i++) begin
      send_word(16'(order[i] * 2), 16'($urandom));
    end
    end_session(ff50_same);
  endtask

  initial begin
    reset_n   = 1'b0;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = '0;
    dl_data   = '0;
    cpu_addr  = '0;
    ff50_wr   = 1'b0;
    ff50_din  = '0;
    for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
    model_reset();

    // Reset values
    repeat (3) tick();
    chk1("rst_dl_wait", dl_wait, 1'b0);
    chk1("rst_rom_valid", rom_valid, 1'b0);
    chk1("rst_boot_enabled", boot_enabled, 1'b0);
    chk8("rst_cpu_data", cpu_data, 8'hFF);
    chk8("rst_checksum", checksum, 8'h00);
    reset_n = 1'b1;
    tick();
    read_chk(8'h10);

    // Counting-pattern image: byte n = n, sum of 0..255 wraps to 0x80
    start_session();
    for (int k = 0; k < 128; k++) begin
      send_word(16'(2 * k), {8'(2 * k + 1), 8'(2 * k)});
    end
    end_session(1'b0);
    chk8("pattern_checksum", checksum, 8'h80);
    read_chk(8'h37);
    chk8("pattern_byte37", cpu_data, 8'h37);
    read_chk(8'h00);
    read_chk(8'hFF);

    // FF50: bit0=0 is ignored, bit0=1 clears the latch
    ff50_wr  = 1'b1;
    ff50_din = 8'($urandom) & 8'hFE;
    tick();
    ff50_wr = 1'b0;
    chk1("ff50_even_noeffect", boot_enabled, 1'b1);
    ff50_wr  = 1'b1;
    ff50_din = 8'($urandom) | 8'h01;
    tick();
    ff50_wr  = 1'b0;
    model_be = 1'b0;
    chk1("ff50_clear", boot_enabled, 1'b0);
    read_chk(8'h80);

    // Random image in shuffled word order re-enables boot ROM
    random_full_load(1'b0);
    for (int i = 0; i < 40; i++) read_chk(8'($urandom));

    // Back-to-back strobes: second one lands while dl_wait=1 and is dropped
    start_session();
    read_chk(8'($urandom));
    dl_addr = 16'h0020; dl_data = 16'h5AA5; dl_wr = 1'b1;
    tick();
    chk1("b2b_wait_first", dl_wait, 1'b1);
    dl_addr = 16'h0040; dl_data = 16'h1234;
    tick();
    dl_wr = 1'b0;
    chk1("b2b_wait_after", dl_wait, 1'b0);
    mmem[8'h20] = 8'hA5; mmem[8'h21] = 8'h5A;
    model_sum = 8'hA5 + 8'h5A;
    model_cnt = 2;
    for (int k = 2; k < 128; k++) begin
      if (k != 16) send_word(16'(2 * k), 16'($urandom));
    end
    end_session(1'b0);
    read_chk(8'h40);
    read_chk(8'h20);

    // Partial load of 64 words leaves no valid image
    start_session();
    for (int k = 0; k < 64; k++) send_word(16'(2 * k), 16'($urandom));
    end_session(1'b0);
    for (int i = 0; i < 8; i++) read_chk(8'($urandom));

    // FF50 clear on the same edge that enters READY
    random_full_load(1'b1);
    chk1("ff50_same_cycle", boot_enabled, 1'b0);
    read_chk(8'($urandom));

    // Out-of-range words are dropped without touching the checksum
    start_session();
    send_word(16'h0000, 16'($urandom));
    send_word(16'h0100, 16'hFFFF);
    chk8("oor_0100_checksum", checksum, model_sum);
    send_word(16'hFFFF, 16'h7777);
    chk8("oor_ffff_checksum", checksum, model_sum);
    send_word(16'h00FE, 16'($urandom));
    chk8("in_range_fe_checksum", checksum, model_sum);

    // Asynchronous reset while dl_wait is high
    dl_addr = 16'h0010; dl_data = 16'($urandom); dl_wr = 1'b1;
    tick();
    dl_wr = 1'b0;
    chk1("pre_reset_wait", dl_wait, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk1("async_rst_dl_wait", dl_wait, 1'b0);
    chk1("async_rst_rom_valid", rom_valid, 1'b0);
    chk8("async_rst_checksum", checksum, 8'h00);
    chk8("async_rst_cpu_data", cpu_data, 8'hFF);
    dl_active = 1'b0;
    model_reset();
    tick();
    reset_n = 1'b1;
    tick();

    // Asynchronous reset while a valid image is being served
    random_full_load(1'b0);
    read_chk(8'($urandom));
    #3 reset_n = 1'b0;
    #1;
    chk1("async_rst_ready_valid", rom_valid, 1'b0);
    chk1("async_rst_ready_boot", boot_enabled, 1'b0);
    chk8("async_rst_ready_data", cpu_data, 8'hFF);
    model_reset();
    tick();
    reset_n = 1'b1;
    read_chk(8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
